spi_cmd_decoder: RTL
====================

Name: spi_cmd_decoder

Overview:
SPI-slave front end of digit_recognizer_final, directly downstream of the SCK/SS/MOSI/MISO pins and upstream of the image buffer and classifier core. It synchronises the SPI pins into the clk domain and deserialises LSB-first bytes. It decodes opcodes, streams pixel-pair bytes into the image buffer and pulses start. It also serves one response byte per SS frame on MISO: the digit, a cost, or an error code.

Parameters:
IMG_BYTES, 72, pixel-pair bytes per image (36 rows x 4 nibble pixels / 2)
SYNC_STAGES, 2, flip-flop depth of the pin synchronisers
ERR_CODE, 8'hFF, response returned while the core is busy

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
SCK  in  1  SPI clock from master, idle low
SS  in  1  slave select, active-low frame
MOSI  in  1  master data, LSB first, sampled on SCK rise
MISO  out  1  slave data, LSB first, changes on SCK fall
buf_wr_en  out  1  one-cycle write strobe to image buffer
buf_addr  out  7  byte address 0..IMG_BYTES-1
buf_data  out  8  {pixel[2k+1], pixel[2k]} nibbles as received
start  out  1  one-cycle pulse: classify loaded image
busy  in  1  core computing; high from cycle after start until done
result_valid  in  1  one-cycle pulse with result_digit
result_digit  in  8  classified digit 0..9
cost_req  out  1  one-cycle pulse requesting cost for cost_digit
cost_digit  out  4  digit argument of cost request
cost_valid  in  1  one-cycle pulse with cost_value
cost_value  in  8  cost for cost_digit

Behaviour:
- Reset: MISO=0, buf_wr_en=0, buf_addr=0, buf_data=0, start=0, cost_req=0, cost_digit=0. Internal resp_reg=8'h00, img_loaded=0, state=IDLE.
- Pins pass through SYNC_STAGES FFs. SCK rise/fall and SS fall/rise are one-cycle edge pulses. Minimum SCK half-period is 4 clk.
- RX: bit_cnt (3b) and shift register are cleared while SS is high. On each SCK rise with SS low: shift MOSI in at bit 7 (LSB first) and increment bit_cnt. At count 8, emit an internal byte_rdy pulse for one cycle. A partial byte at an SS rise is discarded.
- TX: on SS fall, load tx_sr = busy ? ERR_CODE : resp_reg. MISO = tx_sr[0] combinationally, valid within SYNC_STAGES+1 clk of the SS pin fall. Shift right on each SCK fall. MISO=0 while SS is high.
- FSM, state persists across SS frames:
  IDLE: byte 8'h00 and !busy -> LOAD, byte_idx=0. Byte 8'h01 -> COST_ARG. Byte 8'hFF and img_loaded and !busy -> one-cycle start, img_loaded=0. Any other byte, including 8'hFF when not loaded: ignored. This lets read frames clock out 8'hFF harmlessly.
  LOAD: each byte_rdy drives buf_wr_en=1 for one cycle, with buf_addr=byte_idx and buf_data=byte; then byte_idx++. After write IDLE_BYTES-1, i.e. IMG_BYTES-1 -> IDLE, img_loaded=1. No wrap: byte_idx never exceeds IMG_BYTES-1.
  COST_ARG: next byte -> if busy, resp_reg=ERR_CODE; else pulse cost_req with cost_digit=byte[3:0]. Then -> IDLE. A byte value >9 is still forwarded; range checking is the core's job.
- resp_reg updates: result_valid -> result_digit; cost_valid -> cost_value. When start and result_valid coincide, the start pulse wins and result_valid is dropped; this cannot occur in legal operation. Byte_rdy takes priority over SS rise in the same cycle.
- img_loaded is cleared on entry to LOAD, so a restarted load invalidates the prior image.
- Reset mid-frame or mid-load returns all state to reset values immediately. The master must re-send the opcode.

Optional Feature:
SPI_CMD_STATUS_EN:
- Defined: opcode 8'h02 in IDLE sets a one-shot flag. The next frame's TX byte is {5'b0, busy, img_loaded, state!=IDLE} instead of resp_reg; the flag then clears.
- Undefined: 8'h02 is ignored like any unknown opcode.

Decomposition:
- Package dr_spi_pkg holds: opcode constants OP_LOAD=8'h00, OP_COST=8'h01, OP_STATUS=8'h02, OP_START=8'hFF; the state_t enum {IDLE, LOAD, COST_ARG}; and IMG_BYTES.
- One sub-module, spi_sync_edge: parameterised synchroniser plus rise/fall pulse generator, instanced for SCK and SS, with MOSI sync only.

Test Plan:
- Reset, then read frame (master sends 8'hFF) -> MISO byte 8'h00; no start pulse.
- Frame 8'h00, then frame of 72 bytes i (i=0..71) -> 72 buf_wr_en pulses, addr 0..71, data 8'h00..8'h47. Then frame 8'hFF -> exactly one start pulse.
- Hold busy=1 and read -> 8'hFF. Then result_valid with digit 7, busy=0, read -> 8'h07. A second 8'hFF frame gives no start pulse.
- Frames 8'h01, 8'h03 -> cost_req with cost_digit=3. cost_valid with value 8'h2A, then read -> 8'h2A. Repeat with busy=1 -> no cost_req, read -> 8'hFF.
- Load aborted after 30 bytes with rst pulse -> outputs at reset values. A later 8'hFF -> no start. A fresh full load restarts at addr 0.
- Frame raised after 5 bits -> no byte_rdy. The next full byte decodes correctly. With SPI_CMD_STATUS_EN: 8'h02 with img_loaded=1, then read -> 8'h02.

Source files
------------

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared opcodes, FSM state type and image size for the digit_recognizer SPI front end.
package dr_spi_pkg;

    localparam int IMG_BYTES = 72;

    localparam logic [7:0] OP_LOAD   = 8'h00;
    localparam logic [7:0] OP_COST   = 8'h01;
    localparam logic [7:0] OP_STATUS = 8'h02;
    localparam logic [7:0] OP_START  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        COST_ARG = 2'd2
    } state_t;

endpackage

// File: rtl/spi_cmd_decoder_sync_edge.sv
// Multi-stage pin synchroniser with one-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI slave command decoder: LSB-first byte RX/TX, opcode FSM, image-buffer writes.
// Optional status opcode (8'h02) is built in when SPI_CMD_STATUS_EN is defined.
module spi_cmd_decoder #(
    parameter int         IMG_BYTES   = 72,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ERR_CODE    = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    output logic       buf_wr_en,
    output logic [6:0] buf_addr,
    output logic [7:0] buf_data,
    output logic       start,
    input  logic       busy,
    input  logic       result_valid,
    input  logic [7:0] result_digit,
    output logic       cost_req,
    output logic [3:0] cost_digit,
    input  logic       cost_valid,
    input  logic [7:0] cost_value
);
    import dr_spi_pkg::*;

    localparam logic [6:0] LAST_IDX = 7'(IMG_BYTES - 1);

    logic                   sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   mosi_s;
    logic                   frame_on;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sr;
    logic                   byte_rdy;
    logic [7:0]             tx_sr;
    logic [7:0]             tx_load;
    logic [7:0]             resp_reg;
    logic                   img_loaded;
    logic [6:0]             byte_idx;
    state_t                 state;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .pin(SCK), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .pin(SS), .rise(ss_rise), .fall(ss_fall)
    );

    // MOSI gets the same depth as SCK so the sampled bit stays aligned with its edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_chain <= '0;
        else     mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    // frame_on drops one cycle after ss_rise, so a final SCK rise in that cycle still lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_on <= 1'b0;
            bit_cnt  <= 3'd0;
            rx_sr    <= 8'h00;
            byte_rdy <= 1'b0;
        end else begin
            if (ss_fall)      frame_on <= 1'b1;
            else if (ss_rise) frame_on <= 1'b0;

            byte_rdy <= frame_on && sck_rise && (bit_cnt == 3'd7);
            if (!frame_on) begin
                bit_cnt <= 3'd0;
                rx_sr   <= 8'h00;
            end else if (sck_rise) begin
                rx_sr   <= {mosi_s, rx_sr[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

`ifdef SPI_CMD_STATUS_EN
    logic status_pend;
    always_comb begin
        tx_load = busy ? ERR_CODE : resp_reg;
        if (status_pend)
            tx_load = {5'b0, busy, img_loaded, state != IDLE};
    end
`else
    always_comb begin
        tx_load = busy ? ERR_CODE : resp_reg;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       tx_sr <= 8'h00;
        else if (ss_fall)              tx_sr <= tx_load;
        else if (sck_fall && frame_on) tx_sr <= {1'b0, tx_sr[7:1]};
    end

    assign MISO = frame_on & tx_sr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_idx   <= 7'd0;
            img_loaded <= 1'b0;
            resp_reg   <= 8'h00;
            buf_wr_en  <= 1'b0;
            buf_addr   <= 7'd0;
            buf_data   <= 8'h00;
            start      <= 1'b0;
            cost_req   <= 1'b0;
            cost_digit <= 4'd0;
`ifdef SPI_CMD_STATUS_EN
            status_pend <= 1'b0;
`endif
        end else begin
            buf_wr_en <= 1'b0;
            start     <= 1'b0;
            cost_req  <= 1'b0;

            if (result_valid && !start) resp_reg <= result_digit;
            if (cost_valid)             resp_reg <= cost_value;
`ifdef SPI_CMD_STATUS_EN
            if (ss_fall) status_pend <= 1'b0;
`endif

            if (byte_rdy) begin
                case (state)
                    IDLE: begin
                        if (rx_sr == OP_LOAD && !busy) begin
                            state      <= LOAD;
                            byte_idx   <= 7'd0;
                            img_loaded <= 1'b0;
                        end else if (rx_sr == OP_COST) begin
                            state <= COST_ARG;
                        end else if (rx_sr == OP_START && img_loaded && !busy) begin
                            start      <= 1'b1;
                            img_loaded <= 1'b0;
                        end
`ifdef SPI_CMD_STATUS_EN
                        else if (rx_sr == OP_STATUS) begin
                            status_pend <= 1'b1;
                        end
`endif
                    end
                    LOAD: begin
                        buf_wr_en <= 1'b1;
                        buf_addr  <= byte_idx;
                        buf_data  <= rx_sr;
                        if (byte_idx == LAST_IDX) begin
                            state      <= IDLE;
                            img_loaded <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 7'd1;
                        end
                    end
                    COST_ARG: begin
                        if (busy) begin
                            resp_reg <= ERR_CODE;
                        end else begin
                            cost_req   <= 1'b1;
                            cost_digit <= rx_sr[3:0];
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
